polar_frame_streamer: RTL and testbench

- Consumer end of the polar frame produced by the cartesian-to-polar mapper.
- Double-buffers one polar frame (NO_DELTA_INTERVALS slices × NO_ARM_LED pixels).
- On each angle tick from the rotation timing logic, streams the current slice pixel-by-pixel to the LED arm driver over a valid/ready handshake.
- rev_sync realigns the slice counter to slice 0 and is the only point where a new frame replaces the displayed one.

---
 rtl/polar_frame_streamer.sv | 174 +++++++++++++++++
 tb/tb_polar_frame_streamer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_frame_streamer.sv
// Double-buffered polar frame store that streams one slice per angle trigger over valid/ready.
// Build option PFS_ARM_REVERSE_EN streams each slice from the outer LED inward.
module polar_frame_streamer #(
  parameter int NO_ARM_LED         = 32,
  parameter int NO_DELTA_INTERVALS = 16,
  parameter int RGB_SIZE           = 8,
  parameter int OUT_DIM            = NO_DELTA_INTERVALS * NO_ARM_LED * RGB_SIZE,
  parameter int SLICE_W            = $clog2(NO_DELTA_INTERVALS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OUT_DIM-1:0]  frame_data,
  input  logic                frame_valid,
  input  logic                angle_tick,
  input  logic                rev_sync,
  output logic [RGB_SIZE-1:0] pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_last,
  output logic [SLICE_W-1:0]  slice_idx,
  output logic                frame_loaded,
  output logic                overrun
);

  localparam int LED_W = (NO_ARM_LED > 1) ? $clog2(NO_ARM_LED) : 1;
  localparam logic [LED_W-1:0]   LED_MAX   = LED_W'(NO_ARM_LED - 1);
  localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'(NO_DELTA_INTERVALS - 1);

`ifdef PFS_ARM_REVERSE_EN
  localparam logic [LED_W-1:0] LED_FIRST = LED_MAX;
  localparam logic [LED_W-1:0] LED_FINAL = '0;
`else
  localparam logic [LED_W-1:0] LED_FIRST = '0;
  localparam logic [LED_W-1:0] LED_FINAL = LED_MAX;
`endif

  // Packed so that [s][l] lands exactly on bits [(s*NO_ARM_LED+l)*RGB_SIZE +: RGB_SIZE].
  typedef logic [NO_DELTA_INTERVALS-1:0][NO_ARM_LED-1:0][RGB_SIZE-1:0] frame_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t             state, state_nxt;
  frame_t             shadow, active;
  logic               shadow_full;
  logic               frame_valid_d;
  logic [SLICE_W-1:0] nxt_slice;
  logic [LED_W-1:0]   led;
  logic               pending;
  logic               pending_rev;
  logic [SLICE_W-1:0] pend_slice;

  logic               trigger;
  logic [SLICE_W-1:0] trig_slice;
  logic [SLICE_W-1:0] trig_next;
  logic               capture;
  logic               handshake;
  logic               last_hs;
  logic               start;
  logic [SLICE_W-1:0] start_slice;
  logic               start_rev;
  logic               promote;
  logic [LED_W-1:0]   led_step;

  // rev_sync dominates a simultaneous angle_tick and always means slice 0.
  assign trigger    = angle_tick | rev_sync;
  assign trig_slice = rev_sync ? '0 : nxt_slice;
  assign trig_next  = (trig_slice == SLICE_MAX) ? '0 : trig_slice + SLICE_W'(1);

  assign capture    = frame_valid & ~frame_valid_d;
  assign handshake  = (state == S_STREAM) & pix_ready;
  assign last_hs    = handshake & (led == LED_FINAL);

  // A queued trigger is always serviced before a live one.
  assign start       = (state == S_WAIT) & (pending | trigger);
  assign start_slice = pending ? pend_slice : trig_slice;
  assign start_rev   = pending ? pending_rev : rev_sync;

  // The displayed frame only changes on first load or at a revolution boundary.
  assign promote = shadow_full & ((state == S_IDLE) | (start & start_rev));

`ifdef PFS_ARM_REVERSE_EN
  assign led_step = led - LED_W'(1);
`else
  assign led_step = led + LED_W'(1);
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (shadow_full) state_nxt = S_WAIT;
      S_WAIT:   if (start)       state_nxt = S_STREAM;
      S_STREAM: if (last_hs)     state_nxt = S_WAIT;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    if (state == S_STREAM) begin
      pix_valid = 1'b1;
      pix_data  = active[slice_idx][led];
      pix_last  = (led == LED_FINAL);
    end
  end

  // NOTE: both frame buffers are cleared on reset so nothing stale can be streamed afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow        <= '0;
      active        <= '0;
      shadow_full   <= 1'b0;
      frame_valid_d <= 1'b0;
      frame_loaded  <= 1'b0;
      nxt_slice     <= '0;
      slice_idx     <= '0;
      led           <= '0;
      pending       <= 1'b0;
      pending_rev   <= 1'b0;
      pend_slice    <= '0;
      overrun       <= 1'b0;
    end else begin
      frame_valid_d <= frame_valid;

      if (promote) begin
        active       <= shadow;
        shadow_full  <= 1'b0;
        frame_loaded <= 1'b1;
      end
      // Written after the promotion so a same-cycle capture keeps the shadow marked full.
      if (capture) begin
        shadow      <= frame_data;
        shadow_full <= 1'b1;
      end

      if (state == S_IDLE) begin
        if (rev_sync) nxt_slice <= '0;
      end else if (trigger) begin
        nxt_slice <= trig_next;
      end

      if (start) begin
        slice_idx <= start_slice;
        led       <= LED_FIRST;
      end else if (handshake && !last_hs) begin
        led <= led_step;
      end

      if (start && pending) begin
        // A live trigger arriving while the queued one is serviced stays queued.
        pending     <= trigger;
        pend_slice  <= trig_slice;
        pending_rev <= rev_sync;
      end else if (trigger && state == S_STREAM) begin
        pending     <= 1'b1;
        pend_slice  <= trig_slice;
        pending_rev <= pending_rev | rev_sync;
        if (pending) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_polar_frame_streamer.sv
// Scoreboard bench for polar_frame_streamer: stimulus pushes expected pixels, a monitor pops
// and compares them on every handshake while also watching stall stability and slice gaps.
module tb_polar_frame_streamer;

  localparam int S       = 16;
  localparam int L       = 32;
  localparam int W       = 8;
  localparam int OUT_DIM = S * L * W;
  localparam int SW      = 4;

`ifdef PFS_ARM_REVERSE_EN
  localparam int FIRST_L = L - 1;
`else
  localparam int FIRST_L = 0;
`endif

  typedef logic [S-1:0][L-1:0][W-1:0] frame_t;
  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic [SW-1:0] slice;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset;
  logic [OUT_DIM-1:0] frame_data;
  logic               frame_valid;
  logic               angle_tick;
  logic               rev_sync;
  logic [W-1:0]       pix_data;
  logic               pix_valid;
  logic               pix_ready;
  logic               pix_last;
  logic [SW-1:0]      slice_idx;
  logic               frame_loaded;
  logic               overrun;

  polar_frame_streamer #(
    .NO_ARM_LED(L),
    .NO_DELTA_INTERVALS(S),
    .RGB_SIZE(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .angle_tick(angle_tick),
    .rev_sync(rev_sync),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_last(pix_last),
    .slice_idx(slice_idx),
    .frame_loaded(frame_loaded),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   exp_q[$];

  // Reference model: displayed frame, waiting frame, next slice, queued revolution flag.
  frame_t m_disp;
  frame_t m_shad;
  bit     m_sf;
  bit     m_loaded;
  bit     m_pend_rev;
  int     m_nxt;

  int     rdy_mode;
  int     rdy_phase;

  exp_t         mon_e;
  bit           was_stall;
  bit           was_last_hs;
  logic [W-1:0] stall_data;
  logic         stall_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_slice(input int s);
    exp_t e;
    for (int i = 0; i < L; i++) begin
      int l;
`ifdef PFS_ARM_REVERSE_EN
      l = L - 1 - i;
`else
      l = i;
`endif
      e.data  = m_disp[4'(s)][5'(l)];
      e.last  = (i == L - 1);
      e.slice = 4'(s);
      exp_q.push_back(e);
    end
  endtask

  // push=0 marks a trigger that will be overwritten before it is serviced.
  task automatic model_trigger(input bit r, input bit push);
    int s;
    if (!m_loaded) begin
      if (r) m_nxt = 0;
      return;
    end
    s = r ? 0 : m_nxt;
    m_nxt = (s + 1) % S;
    m_pend_rev |= r;
    if (push) begin
      if (m_pend_rev && m_sf) begin
        m_disp = m_shad;
        m_sf   = 1'b0;
      end
      m_pend_rev = 1'b0;
      push_slice(s);
    end
  endtask

  task automatic trig(input bit t, input bit r, input bit push);
    angle_tick = t;
    rev_sync   = r;
    tick();
    angle_tick = 1'b0;
    rev_sync   = 1'b0;
    model_trigger(r, push);
  endtask

  task automatic load_frame(input frame_t f);
    bit was;
    was = m_loaded;
    frame_data  = f;
    frame_valid = 1'b1;
    tick();
    check("load_pending", 32'(frame_loaded), 32'(was));
    tick();
    check("load_done", 32'(frame_loaded), 1);
    frame_valid = 1'b0;
    m_shad = f;
    m_sf   = 1'b1;
    if (!m_loaded) begin
      m_disp   = f;
      m_sf     = 1'b0;
      m_loaded = 1'b1;
    end
    tick();
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pix_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
    tick();
  endtask

  // Monitor: samples on the falling edge, between the driving and capturing rising edges.
  always @(negedge clock) begin
    if (reset) begin
      was_stall   = 1'b0;
      was_last_hs = 1'b0;
    end else begin
      if (was_stall) begin
        check("stall_valid", 32'(pix_valid), 1);
        check("stall_data", 32'(pix_data), 32'(stall_data));
        check("stall_last", 32'(pix_last), 32'(stall_last));
      end
      if (was_last_hs) check("slice_gap", 32'(pix_valid), 0);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pix_unexpected: got data 0x%0h slice %0d, expected no pixel at %0t",
                   pix_data, slice_idx, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(mon_e.data));
          check("pix_last", 32'(pix_last), 32'(mon_e.last));
          check("slice_idx", 32'(slice_idx), 32'(mon_e.slice));
        end
      end
      was_stall   = pix_valid && !pix_ready;
      stall_data  = pix_data;
      stall_last  = pix_last;
      was_last_hs = pix_valid && pix_ready && pix_last;
    end
  end

  // Ready driver: 0 = always ready, 1 = 1,0,0 pattern, 2 = held off, 3 = random.
  initial begin
    pix_ready = 1'b1;
    rdy_phase = 0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        1: begin
          pix_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        2:       pix_ready = 1'b0;
        3:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t fa, fb, fc, fd;
    bit r, t;

    reset = 1'b1; frame_valid = 1'b0; angle_tick = 1'b0; rev_sync = 1'b0;
    frame_data = '0; rdy_mode = 0;
    m_sf = 1'b0; m_loaded = 1'b0; m_pend_rev = 1'b0; m_nxt = 0;
    m_disp = '0; m_shad = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_pix_last", 32'(pix_last), 0);
    check("rst_slice_idx", 32'(slice_idx), 0);
    check("rst_frame_loaded", 32'(frame_loaded), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Load frame A and stream slice 0.
    for (int s = 0; s < S; s++)
      for (int l = 0; l < L; l++)
        fa[4'(s)][5'(l)] = 8'((s * L + l) & 255);
    load_frame(fa);
    trig(1'b0, 1'b1, 1'b1);
    check("first_valid", 32'(pix_valid), 1);
    check("first_data", 32'(pix_data), 32'(FIRST_L));
    check("first_slice", 32'(slice_idx), 0);
    drain("drain_first", 100);

    // Full revolution: slices 1..15 then wrap to 0.
    trig(1'b0, 1'b1, 1'b1);
    repeat (39) tick();
    for (int i = 1; i <= S; i++) begin
      trig(1'b1, 1'b0, 1'b1);
      if (i == 3)  check("slice3_first", 32'(pix_data), 32'((3 * L + FIRST_L) & 255));
      if (i == 15) check("slice15_first", 32'(pix_data), 32'((15 * L + FIRST_L) & 255));
      if (i == S)  check("wrap_slice", 32'(slice_idx), 0);
      repeat (39) tick();
    end
    drain("drain_rev", 100);

    // Backpressure with the 1,0,0 ready pattern.
    rdy_mode = 1;
    repeat (2) tick();
    repeat (3) begin
      trig(1'b1, 1'b0, 1'b1);
      drain("drain_bp", 300);
    end

    // Overrun: three triggers while the stream is stalled; the last one wins.
    rdy_mode = 2;
    repeat (2) tick();
    trig(1'b1, 1'b0, 1'b1);
    tick();
    trig(1'b1, 1'b0, 1'b0);
    check("overrun_first", 32'(overrun), 0);
    trig(1'b1, 1'b0, 1'b0);
    check("overrun_set", 32'(overrun), 1);
    trig(1'b1, 1'b0, 1'b1);
    rdy_mode = 0;
    drain("drain_overrun", 200);
    check("overrun_sticky", 32'(overrun), 1);

    // Trigger landing on the same cycle as the final handshake is queued.
    repeat (2) tick();
    trig(1'b1, 1'b0, 1'b1);
    repeat (L - 1) tick();
    trig(1'b1, 1'b0, 1'b1);
    check("lastcycle_gap", 32'(pix_valid), 0);
    tick();
    check("lastcycle_pending", 32'(pix_valid), 1);
    drain("drain_lastcycle", 100);

    // Frame B waits in the shadow until the next revolution.
    for (int s = 0; s < S; s++)
      for (int l = 0; l < L; l++)
        fb[4'(s)][5'(l)] = 8'hAA;
    load_frame(fb);
    repeat (3) begin
      trig(1'b1, 1'b0, 1'b1);
      drain("drain_swap_old", 100);
    end
    trig(1'b0, 1'b1, 1'b1);
    check("swap_data", 32'(pix_data), 32'hAA);
    drain("drain_swap_new", 100);
    trig(1'b1, 1'b0, 1'b1);
    drain("drain_swap_next", 100);
    trig(1'b1, 1'b1, 1'b1);
    check("both_slice0", 32'(slice_idx), 0);
    drain("drain_both", 100);

    // Reset while pixel 10 is on the bus.
    trig(1'b1, 1'b0, 1'b1);
    repeat (10) tick();
    check("overrun_before_reset", 32'(overrun), 1);
    reset = 1'b1;
    tick();
    check("midrst_pix_valid", 32'(pix_valid), 0);
    check("midrst_frame_loaded", 32'(frame_loaded), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_slice_idx", 32'(slice_idx), 0);
    exp_q.delete();
    m_sf = 1'b0; m_loaded = 1'b0; m_pend_rev = 1'b0; m_nxt = 0;
    reset = 1'b0;
    tick();
    trig(1'b1, 1'b0, 1'b1);
    repeat (5) tick();
    trig(1'b0, 1'b1, 1'b1);
    repeat (40) tick();
    check("idle_no_valid", 32'(pix_valid), 0);
    check("idle_not_loaded", 32'(frame_loaded), 0);

    // Random frames, random triggers, random backpressure.
    for (int s = 0; s < S; s++)
      for (int l = 0; l < L; l++)
        fc[4'(s)][5'(l)] = 8'($urandom);
    load_frame(fc);
    trig(1'b0, 1'b1, 1'b1);
    drain("drain_rand_first", 100);
    rdy_mode = 3;
    for (int it = 0; it < 12; it++) begin
      if (it == 6) begin
        for (int s = 0; s < S; s++)
          for (int l = 0; l < L; l++)
            fd[4'(s)][5'(l)] = 8'($urandom);
        load_frame(fd);
      end
      r = ($urandom_range(0, 3) == 0);
      t = !r || ($urandom_range(0, 1) == 1);
      trig(t, r, 1'b1);
      drain("drain_rand", 600);
    end

    rdy_mode = 0;
    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
